// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem address, IF/ID buffer
// Optional FETCH_PERF_EN adds saturating fetchCount/stallCount outputs.
module fetch_stage #(
    parameter int          SIZE     = 16,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_INC   = 2,
    parameter logic [15:0] NOP      = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'b1111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcWrite,
    input  logic            fetchWrite,
    input  logic            flush,
    input  logic            branchTaken,
    input  logic [SIZE-1:0] branchTarget,
    input  logic [SIZE-1:0] imemData,
    output logic [SIZE-1:0] imemAddr,
    output logic [SIZE-1:0] ifidInstr,
    output logic [SIZE-1:0] ifidPc,
    output logic            ifidValid,
`ifdef FETCH_PERF_EN
    output logic [SIZE-1:0] fetchCount,
    output logic [SIZE-1:0] stallCount,
`endif
    output logic            halted
);
    typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] pc, pc_nxt, pc_inc;
    logic [SIZE-1:0] instr_nxt, ifpc_nxt;
    logic            valid_nxt, halted_nxt;
    logic            fetch_inc, stall_inc;

    assign imemAddr = pc;
    assign pc_inc   = pc + SIZE'(PC_INC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            pc        <= SIZE'(RESET_PC);
            ifidInstr <= SIZE'(NOP);
            ifidPc    <= '0;
            ifidValid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ifidInstr <= instr_nxt;
            ifidPc    <= ifpc_nxt;
            ifidValid <= valid_nxt;
            halted    <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = ifidInstr;
        ifpc_nxt   = ifidPc;
        valid_nxt  = ifidValid;
        halted_nxt = 1'b0;
        fetch_inc  = 1'b0;
        stall_inc  = 1'b0;
        case (state)
            HALT: begin
                instr_nxt = SIZE'(NOP);
                valid_nxt = 1'b0;
                if (branchTaken) begin
                    pc_nxt    = branchTarget;
                    state_nxt = RUN;
                end else begin
                    halted_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                stall_inc = (state == RUN) && pcWrite && !branchTaken;
                if (branchTaken) begin
                    pc_nxt    = branchTarget;
                    instr_nxt = SIZE'(NOP);
                    valid_nxt = 1'b0;
                end else if (flush) begin
                    instr_nxt = SIZE'(NOP);
                    valid_nxt = 1'b0;
                    if (!pcWrite) pc_nxt = pc_inc;
                end else if (pcWrite || fetchWrite) begin
                    // Holds are independent; a partial hold is not a plain capture, so no halt check.
                    if (!pcWrite) pc_nxt = pc_inc;
                    if (!fetchWrite) begin
                        instr_nxt = imemData;
                        ifpc_nxt  = pc;
                        valid_nxt = 1'b1;
                    end
                end else begin
                    instr_nxt = imemData;
                    ifpc_nxt  = pc;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_inc;
                    fetch_inc = 1'b1;
                    if (imemData[SIZE-1 -: 4] == HALT_OP) begin
                        state_nxt  = HALT;
                        halted_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (fetch_inc && !(&fetchCount)) fetchCount <= fetchCount + 1'b1;
            if (stall_inc && !(&stallCount)) stallCount <= stallCount + 1'b1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_inc ^ stall_inc;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, pcWrite, fetchWrite, flush, branchTaken;
    logic [15:0] branchTarget, imemData, imemAddr, ifidInstr, ifidPc;
    logic        ifidValid, halted;
`ifdef FETCH_PERF_EN
    logic [15:0] fetchCount, stallCount;
`endif
    logic [15:0] mem [0:255];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always_comb imemData = mem[imemAddr[8:1]];

    fetch_stage dut (
        .clk(clk), .rst(rst), .pcWrite(pcWrite), .fetchWrite(fetchWrite),
        .flush(flush), .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemData(imemData), .imemAddr(imemAddr), .ifidInstr(ifidInstr),
        .ifidPc(ifidPc), .ifidValid(ifidValid),
`ifdef FETCH_PERF_EN
        .fetchCount(fetchCount), .stallCount(stallCount),
`endif
        .halted(halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [15:0] ins, input logic [15:0] pc,
                        input logic v, input logic [15:0] addr);
        chk({tag, "_instr"}, ifidInstr, ins);
        if (v) chk({tag, "_pc"}, ifidPc, pc);
        chk({tag, "_valid"}, {15'd0, ifidValid}, {15'd0, v});
        chk({tag, "_addr"}, imemAddr, addr);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
        mem[3] = 16'h4567; mem[4] = 16'hF000;
        mem[8'h10] = 16'h5020; mem[8'h20] = 16'h4040;
        rst = 1; pcWrite = 0; fetchWrite = 0; flush = 0; branchTaken = 0; branchTarget = 0;
        step;
        ifid("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("reset_ifidpc", ifidPc, 16'h0000);
        chk("reset_halted", {15'd0, halted}, 16'h0000);

        rst = 0;
        step; ifid("seq0", 16'h1234, 16'h0000, 1'b1, 16'h0002);
        step; ifid("seq1", 16'h2345, 16'h0002, 1'b1, 16'h0004);
        pcWrite = 1; fetchWrite = 1;
        step; ifid("hold", 16'h2345, 16'h0002, 1'b1, 16'h0004);
        pcWrite = 0; fetchWrite = 0;
        step; ifid("seq2", 16'h3456, 16'h0004, 1'b1, 16'h0006);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", fetchCount, 16'd3);
        chk("perf_stall", stallCount, 16'd1);
`endif

        branchTaken = 1; branchTarget = 16'h0040; pcWrite = 1; fetchWrite = 1;
        step; ifid("br", 16'h0000, 16'h0000, 1'b0, 16'h0040);
        branchTaken = 0; pcWrite = 0; fetchWrite = 0;
        step; ifid("br_tgt", 16'h4040, 16'h0040, 1'b1, 16'h0042);

        branchTaken = 1; branchTarget = 16'h0008;
        step; ifid("to8", 16'h0000, 16'h0000, 1'b0, 16'h0008);
        branchTaken = 0;
        step; ifid("halt_ins", 16'hF000, 16'h0008, 1'b1, 16'h000A);
        chk("halt_set", {15'd0, halted}, 16'h0001);
        flush = 1; pcWrite = 1; fetchWrite = 1;
        step; ifid("halt_nop", 16'h0000, 16'h0000, 1'b0, 16'h000A);
        chk("halt_stay", {15'd0, halted}, 16'h0001);
        flush = 0; pcWrite = 0; fetchWrite = 0;
        step; ifid("halt_nop2", 16'h0000, 16'h0000, 1'b0, 16'h000A);
        branchTaken = 1; branchTarget = 16'h0020;
        step; ifid("unhalt", 16'h0000, 16'h0000, 1'b0, 16'h0020);
        chk("unhalt_flag", {15'd0, halted}, 16'h0000);
        branchTaken = 0;
        step; ifid("resume", 16'h5020, 16'h0020, 1'b1, 16'h0022);

        flush = 1;
        step; ifid("flush", 16'h0000, 16'h0000, 1'b0, 16'h0024);
        pcWrite = 1;
        step; ifid("flush_hold", 16'h0000, 16'h0000, 1'b0, 16'h0024);
        flush = 0;
        step; ifid("pchold_only", 16'h1012, 16'h0024, 1'b1, 16'h0024);
        pcWrite = 0; fetchWrite = 1;
        step; ifid("fwhold_only", 16'h1012, 16'h0024, 1'b1, 16'h0026);
        fetchWrite = 0;

        branchTaken = 1; branchTarget = 16'hFFFE;
        step; ifid("wrap_br", 16'h0000, 16'h0000, 1'b0, 16'hFFFE);
        branchTaken = 0;
        step; ifid("wrap", 16'h10FF, 16'hFFFE, 1'b1, 16'h0000);

        step; step;
        pcWrite = 1; fetchWrite = 1; rst = 1;
        step; ifid("rst_hold", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("rst_hold_pc", ifidPc, 16'h0000);
        pcWrite = 0; fetchWrite = 0; rst = 0;
        branchTaken = 1; branchTarget = 16'h0008;
        step;
        branchTaken = 0;
        step; chk("halt2_set", {15'd0, halted}, 16'h0001);
        rst = 1;
        step; ifid("rst_halt", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("rst_halt_pc", ifidPc, 16'h0000);
        chk("rst_halt_flag", {15'd0, halted}, 16'h0000);
`ifdef FETCH_PERF_EN
        chk("rst_fetchcnt", fetchCount, 16'd0);
        chk("rst_stallcnt", stallCount, 16'd0);
`endif
        rst = 0;
        step; ifid("post_rst", 16'h1234, 16'h0000, 1'b1, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined CPU. Holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline buffer that feeds decode. It consumes the hold requests (`pcWrite`, `fetchWrite`) from the hazard detection unit and the redirect and flush requests from the branch/control logic. It also stops fetching on a HALT instruction.

## Interface
- `SIZE`, 16, data/instruction/PC width
- `RESET_PC`, 16'h0000, PC value after reset
- `PC_INC`, 2, PC increment per fetched instruction (byte-addressed 16-bit words)
- `NOP`, 16'h0000, encoding inserted into IF/ID on flush, bubble or halt
- `HALT_OP`, 4'b1111, opcode (bits [15:12]) that halts fetch

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `pcWrite`  in  1  from hazard unit; 1 = hold PC this cycle
- `fetchWrite`  in  1  from hazard unit; 1 = hold IF/ID contents this cycle
- `flush`  in  1  from control unit; 1 = replace IF/ID with NOP
- `branchTaken`  in  1  redirect request from EX
- `branchTarget`  in  SIZE  redirect PC
- `imemData`  in  SIZE  instruction at `imemAddr`, combinational read
- `imemAddr`  out  SIZE  equals current PC, combinational
- `ifidInstr`  out  SIZE  registered instruction to decode
- `ifidPc`  out  SIZE  registered PC of `ifidInstr`
- `ifidValid`  out  1  registered; 1 = `ifidInstr` is a real fetched instruction
- `halted`  out  1  registered; 1 while FSM is in HALT

## Operation
- FSM states:
  - `FILL`: the single cycle after reset.
  - `RUN`: normal fetching.
  - `HALT`: fetch stopped.
- Reset (`rst`=1 at edge):
  - PC ← `RESET_PC`
  - `ifidInstr` ← `NOP`, `ifidPc` ← 0, `ifidValid` ← 0, `halted` ← 0
  - state ← `FILL`
- `FILL` → `RUN` unconditionally.
  - In `FILL`, IF/ID captures `imemData`/PC normally and PC advances, unless a hold or redirect is active.
- Per-edge priority in `FILL`/`RUN`, highest first:
  1. `branchTaken`: PC ← `branchTarget`; IF/ID ← `NOP`, valid 0. Overrides both holds.
  2. `flush`: IF/ID ← `NOP`, valid 0. PC advances by `PC_INC` unless `pcWrite`=1.
  3. Holds: `pcWrite`=1 freezes PC; `fetchWrite`=1 freezes all IF/ID registers. The two holds are applied independently.
  4. Otherwise: IF/ID ← {`imemData`, PC, 1}; PC ← PC + `PC_INC`.
- Halt detection: applies when case 4 captures an instruction with `imemData[15:12]` == `HALT_OP`.
  - The HALT instruction itself is passed to decode with valid 1.
  - PC still advances.
  - State ← `HALT`; `halted` ← 1.
- `HALT` state:
  - PC frozen.
  - IF/ID ← `NOP`, valid 0 each cycle; holds and `flush` are ignored.
  - `branchTaken` in HALT: PC ← `branchTarget`, state ← `RUN`, `halted` ← 0. This covers an older branch that resolves after the halt was fetched.
  - Otherwise HALT persists until `rst`.
- Arithmetic: PC + `PC_INC` is modulo 2^SIZE. For example, 16'hFFFE + 2 = 16'h0000; no error is raised.

## Timing
- Fetch latency: one cycle. The instruction at PC=A appears on `ifidInstr` with `ifidPc`=A after the next edge.
- Redirect: one cycle. `branchTaken` at edge N puts `branchTarget` on `imemAddr` after N. The target instruction appears on IF/ID after N+1. Exactly one NOP bubble is inserted.
- A hold lasts exactly the cycles its input is high; there is no internal stretching.
- `rst` wins over every other input at the same edge, including mid-halt and mid-hold.
- All outputs except `imemAddr` are registered.

## Configuration
- `FETCH_PERF_EN` defined: adds two output ports, `fetchCount` and `stallCount` (both SIZE, saturating at all-ones, cleared by `rst`).
  - `fetchCount` increments on each case-4 capture.
  - `stallCount` increments on each edge in `RUN` with `pcWrite`=1 and no `branchTaken`.
- `FETCH_PERF_EN` undefined: neither port exists; all other behaviour is identical.

## Test plan
- Reset then sequential fetch, imem[0,2,4]=1111? no → use 16'h1234,16'h2345,16'h3456: IF/ID shows (1234,0),(2345,2),(3456,4) on successive cycles, `ifidValid`=1.
- Load-use hold: `pcWrite`=`fetchWrite`=1 for 1 cycle at PC=4 → PC stays 4, IF/ID unchanged for one cycle, then fetch of 4 resumes.
- Branch at PC=6 with `branchTarget`=16'h0040, with holds also high → next `imemAddr`=0040, IF/ID=NOP/valid 0, then the instruction at 0040 is captured.
- HALT: imem[8]=16'hF000 → IF/ID=(F000,8,1), `halted`=1 next cycle, PC=10 frozen, NOPs thereafter; `branchTaken` to 0x20 → `halted`=0, fetch resumes at 0x20.
- Wrap: `branchTarget`=16'hFFFE, then normal fetch → PC=16'h0000 next cycle.
- Reset asserted mid-hold and in HALT → all outputs at reset values and PC=`RESET_PC` after one edge; with `FETCH_PERF_EN`, counters read 0.
